// File: rtl/mbox_ebox_responder_pkg.sv
// Shared types, widths and helpers for the EBOX-facing MBOX stand-in responder.
package mbox_ebox_responder_pkg;

    localparam int VMA_WIDTH  = 23;
    localparam int WORD_WIDTH = 36;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        PSE_HOLD
    } tMBRState;

    // Odd parity including the parity bit itself, so an all-zero half yields 1.
    function automatic logic oddPar18(input logic [17:0] half);
        return ~(^half);
    endfunction

endpackage

// File: rtl/mbox_ebox_responder_mbr_mem.sv
// Single-port 36-bit backing store: synchronous write, combinational read.
module mbr_mem
    import mbox_ebox_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mbox_ebox_responder.sv
// MBOX stand-in: accepts EBOX requests, answers after a programmable latency,
// and supports read-pause-write cycles locked to a single address.
module mbox_ebox_responder
    import mbox_ebox_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int RD_LAT    = 3,
    parameter int WR_LAT    = 2
) (
    input  logic         mboxClk,
    input  logic         CROBAR,
    input  logic         EBOX_REQ,
    input  logic [13:35] EBOX_VMA,
    input  logic         eboxRead,
    input  logic         eboxWrite,
    input  logic         eboxPSE,
    input  logic [0:35]  cacheDataWrite,
    output logic         cshEBOXT0,
    output logic         mboxRespIn,
    output logic [0:35]  cacheDataRead,
    output logic         CSH_PAR_BIT_A,
    output logic         CSH_PAR_BIT_B,
    output logic         nxmErr,
    output logic         busy
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int ADDR_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [CNT_W-1:0]     RD_LOAD   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]     WR_LOAD   = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [VMA_WIDTH:0]   NXM_LIMIT = (VMA_WIDTH + 1)'(MEM_WORDS);

    tMBRState               state, stateNext;
    logic [CNT_W-1:0]       cnt, cntNext, loadVal;
    logic                   armed;
    logic [VMA_WIDTH-1:0]   vmaIn, vmaQ;
    logic                   rdQ, wrQ, pseQ;
    logic [WORD_WIDTH-1:0]  dataQ, readHold, readVal, memRdata, dataOut;
    logic                   accept, loadReq, lockWrite, respState, respActive;
    logic                   nxm, memWe;

    assign vmaIn   = EBOX_VMA;
    assign loadVal = eboxRead ? RD_LOAD : (eboxWrite ? WR_LOAD : '0);

    // Full VMA compared against depth so high address bits never alias into the array.
    assign nxm        = ({1'b0, vmaQ} >= NXM_LIMIT);
    assign respActive = respState && !CROBAR;
    assign memWe      = respActive && wrQ && !nxm;
    assign readVal    = nxm ? '0 : memRdata;

    mbr_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) uMem (
        .clk   (mboxClk),
        .we    (memWe),
        .addr  (vmaQ[ADDR_W-1:0]),
        .wdata (dataQ),
        .rdata (memRdata)
    );

    // State, request latch, arm logic and the read-data holding register.
    always_ff @(posedge mboxClk) begin
        if (CROBAR) begin
            state    <= IDLE;
            cnt      <= '0;
            armed    <= 1'b1;
            vmaQ     <= '0;
            rdQ      <= 1'b0;
            wrQ      <= 1'b0;
            pseQ     <= 1'b0;
            dataQ    <= '0;
            readHold <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (!EBOX_REQ) begin
                armed <= 1'b1;
            end else if (respActive) begin
                armed <= 1'b0;
            end
            if (accept) begin
                vmaQ  <= vmaIn;
                rdQ   <= eboxRead;
                wrQ   <= eboxWrite;
                pseQ  <= lockWrite ? 1'b0 : eboxPSE;
                dataQ <= cacheDataWrite;
            end
            if (respActive && rdQ) begin
                readHold <= readVal;
            end
        end
    end

    // Next-state: the locked write half of a PSE cycle bypasses the latency counter.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        loadReq   = 1'b0;
        lockWrite = 1'b0;
        respState = 1'b0;
        case (state)
            IDLE: begin
                if (EBOX_REQ && armed) begin
                    accept  = 1'b1;
                    loadReq = 1'b1;
                end
            end
            WAIT: begin
                cntNext = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                respState = 1'b1;
                stateNext = (rdQ && pseQ && !nxm) ? PSE_HOLD : IDLE;
            end
            PSE_HOLD: begin
                if (EBOX_REQ && armed) begin
                    accept = 1'b1;
                    if (eboxWrite && (vmaIn == vmaQ)) begin
                        lockWrite = 1'b1;
                        stateNext = RESP;
                    end else begin
                        loadReq = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        if (loadReq) begin
            cntNext   = loadVal;
            stateNext = (loadVal == '0) ? RESP : WAIT;
        end
    end

    assign dataOut       = (respActive && rdQ) ? readVal : readHold;
    assign cacheDataRead = dataOut;
    assign CSH_PAR_BIT_A = oddPar18(cacheDataRead[0:17]);
    assign CSH_PAR_BIT_B = oddPar18(cacheDataRead[18:35]);
    assign cshEBOXT0     = accept && !CROBAR;
    assign mboxRespIn    = respActive;
    assign nxmErr        = respActive && nxm;
    assign busy          = cshEBOXT0 || ((state == WAIT) && !CROBAR) || respActive;

endmodule

// File: tb/tb_mbox_ebox_responder.sv
// Randomized self-checking bench for mbox_ebox_responder against a transaction-level model.
module tb_mbox_ebox_responder;

    localparam int MEM_WORDS = 4096;
    localparam int RD_LAT    = 3;
    localparam int WR_LAT    = 2;

    logic         mboxClk = 1'b0;
    logic         CROBAR = 1'b1;
    logic         EBOX_REQ = 1'b0;
    logic [13:35] EBOX_VMA = '0;
    logic         eboxRead = 1'b0;
    logic         eboxWrite = 1'b0;
    logic         eboxPSE = 1'b0;
    logic [0:35]  cacheDataWrite = '0;
    logic         cshEBOXT0, mboxRespIn, CSH_PAR_BIT_A, CSH_PAR_BIT_B, nxmErr, busy;
    logic [0:35]  cacheDataRead;

    int testCount = 0;
    int failCount = 0;

    logic [35:0] modelMem [int];
    logic [35:0] lastRead = '0;
    logic        modelLock = 1'b0;
    logic [22:0] lockVma = '0;

    mbox_ebox_responder #(
        .MEM_WORDS (MEM_WORDS),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .mboxClk        (mboxClk),
        .CROBAR         (CROBAR),
        .EBOX_REQ       (EBOX_REQ),
        .EBOX_VMA       (EBOX_VMA),
        .eboxRead       (eboxRead),
        .eboxWrite      (eboxWrite),
        .eboxPSE        (eboxPSE),
        .cacheDataWrite (cacheDataWrite),
        .cshEBOXT0      (cshEBOXT0),
        .mboxRespIn     (mboxRespIn),
        .cacheDataRead  (cacheDataRead),
        .CSH_PAR_BIT_A  (CSH_PAR_BIT_A),
        .CSH_PAR_BIT_B  (CSH_PAR_BIT_B),
        .nxmErr         (nxmErr),
        .busy           (busy)
    );

    always #5 mboxClk = ~mboxClk;

    task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0o expected %0o", tag, actual, expected);
        end
    endtask

    function automatic logic expPar(input logic [17:0] half);
        return ($countones(half) % 2) == 0;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".csh"}, 36'(cshEBOXT0), 36'd0);
        checkOutput({tag, ".resp"}, 36'(mboxRespIn), 36'd0);
        checkOutput({tag, ".nxm"}, 36'(nxmErr), 36'd0);
        checkOutput({tag, ".busy"}, 36'(busy), 36'd0);
        checkOutput({tag, ".data"}, cacheDataRead, 36'd0);
        checkOutput({tag, ".parA"}, 36'(CSH_PAR_BIT_A), 36'd1);
        checkOutput({tag, ".parB"}, 36'(CSH_PAR_BIT_B), 36'd1);
    endtask

    task automatic doReset();
        @(negedge mboxClk);
        CROBAR = 1'b1;
        EBOX_REQ = 1'b0;
        repeat (2) @(negedge mboxClk);
        CROBAR = 1'b0;
        lastRead = '0;
        modelLock = 1'b0;
    endtask

    task automatic driveReq(input logic [22:0] vma, input logic rd, input logic wr, input logic pse,
                            input logic [35:0] wdata);
        EBOX_VMA = vma;
        eboxRead = rd;
        eboxWrite = wr;
        eboxPSE = pse;
        cacheDataWrite = wdata;
        EBOX_REQ = 1'b1;
    endtask

    // One complete transaction: expectations come from the model before the DUT is touched.
    task automatic applyStimulus(input logic [22:0] vma, input logic rd, input logic wr, input logic pse,
                                 input logic [35:0] wdata);
        int          expLat;
        int          seen;
        logic        expNxm;
        logic        lockHit;
        logic [35:0] expData;
        expNxm  = (int'(vma) >= MEM_WORDS);
        lockHit = modelLock && wr && (vma == lockVma);
        expLat  = lockHit ? 1 : (rd ? RD_LAT : (wr ? WR_LAT : 1));
        if (rd) expData = expNxm ? 36'd0 : modelMem[int'(vma)];
        else    expData = lastRead;
        @(negedge mboxClk);
        driveReq(vma, rd, wr, pse, wdata);
        #1;
        checkOutput("accept", 36'(cshEBOXT0), 36'd1);
        checkOutput("busyAccept", 36'(busy), 36'd1);
        seen = 0;
        for (int n = 1; n <= 16 && seen == 0; n++) begin
            @(negedge mboxClk);
            EBOX_REQ = 1'b0;
            #1;
            if (mboxRespIn) seen = n;
        end
        checkOutput("latency", 36'(seen), 36'(expLat));
        if (seen != 0) begin
            checkOutput("nxmErr", 36'(nxmErr), 36'(expNxm));
            checkOutput("readData", cacheDataRead, expData);
            checkOutput("parA", 36'(CSH_PAR_BIT_A), 36'(expPar(expData[35:18])));
            checkOutput("parB", 36'(CSH_PAR_BIT_B), 36'(expPar(expData[17:0])));
            checkOutput("busyResp", 36'(busy), 36'd1);
        end
        if (rd) lastRead = expData;
        if (wr && !expNxm) modelMem[int'(vma)] = wdata;
        modelLock = !lockHit && rd && pse && !expNxm;
        lockVma = vma;
    endtask

    initial begin
        logic [22:0] v;
        logic        r, w, p;
        logic [35:0] d;
        int          accCount, respCount, sel;

        doReset();
        #1;
        checkIdleOutputs("reset");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(23'(i), 1'b0, 1'b1, 1'b0, {4'($urandom), 32'($urandom)});
        end

        applyStimulus(23'o100, 1'b0, 1'b1, 1'b0, 36'o123456701234);
        applyStimulus(23'o100, 1'b1, 1'b0, 1'b0, 36'd0);

        // Level REQ held for ten cycles must be accepted and answered exactly once.
        @(negedge mboxClk);
        driveReq(23'o100, 1'b1, 1'b0, 1'b0, 36'd0);
        accCount = 0;
        respCount = 0;
        for (int n = 0; n < 10; n++) begin
            if (n != 0) @(negedge mboxClk);
            #1;
            if (cshEBOXT0) accCount++;
            if (mboxRespIn) respCount++;
        end
        checkOutput("heldAccepts", 36'(accCount), 36'd1);
        checkOutput("heldResponses", 36'(respCount), 36'd1);
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        lastRead = modelMem[int'(23'o100)];
        applyStimulus(23'o100, 1'b1, 1'b0, 1'b0, 36'd0);

        applyStimulus(23'o200, 1'b0, 1'b1, 1'b0, 36'd5);
        applyStimulus(23'o200, 1'b1, 1'b0, 1'b1, 36'd0);
        applyStimulus(23'o200, 1'b0, 1'b1, 1'b0, 36'd6);
        applyStimulus(23'o200, 1'b1, 1'b0, 1'b0, 36'd0);

        applyStimulus(23'o200, 1'b1, 1'b0, 1'b1, 36'd0);
        applyStimulus(23'o201, 1'b0, 1'b1, 1'b0, 36'd9);
        applyStimulus(23'o200, 1'b1, 1'b0, 1'b0, 36'd0);

        applyStimulus(23'(MEM_WORDS), 1'b1, 1'b0, 1'b0, 36'd0);
        applyStimulus(23'(MEM_WORDS + 5), 1'b0, 1'b1, 1'b0, 36'o777777777777);
        applyStimulus(23'd5, 1'b1, 1'b0, 1'b0, 36'd0);
        applyStimulus(23'o100, 1'b1, 1'b0, 1'b0, 36'd0);

        // Reset landing on the edge that would enter the response cycle.
        applyStimulus(23'o300, 1'b0, 1'b1, 1'b0, 36'o111111111111);
        @(negedge mboxClk);
        driveReq(23'o300, 1'b0, 1'b1, 1'b0, 36'o222222222222);
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        CROBAR = 1'b1;
        #1;
        checkOutput("midResetResp", 36'(mboxRespIn), 36'd0);
        @(negedge mboxClk);
        CROBAR = 1'b0;
        #1;
        checkIdleOutputs("midReset");
        lastRead = '0;
        modelLock = 1'b0;
        applyStimulus(23'o300, 1'b1, 1'b0, 1'b0, 36'd0);

        // Reset held through the response cycle itself must also suppress the write.
        @(negedge mboxClk);
        driveReq(23'd7, 1'b0, 1'b1, 1'b0, 36'o333333333333);
        @(negedge mboxClk);
        EBOX_REQ = 1'b0;
        @(negedge mboxClk);
        CROBAR = 1'b1;
        #1;
        checkOutput("respResetResp", 36'(mboxRespIn), 36'd0);
        @(negedge mboxClk);
        CROBAR = 1'b0;
        lastRead = '0;
        modelLock = 1'b0;
        applyStimulus(23'd7, 1'b1, 1'b0, 1'b0, 36'd0);

        for (int i = 0; i < 150; i++) begin
            r = 1'($urandom);
            w = 1'($urandom);
            p = 1'($urandom);
            d = {4'($urandom), 32'($urandom)};
            sel = int'($urandom_range(0, 9));
            if (modelLock && ($urandom_range(0, 1) == 1)) begin
                v = lockVma;
                w = 1'b1;
            end else if (sel < 8) begin
                v = 23'($urandom_range(0, 15));
            end else if (sel == 8) begin
                v = 23'(MEM_WORDS + int'($urandom_range(0, 63)));
            end else begin
                v = 23'($urandom) | 23'h400000;
            end
            applyStimulus(v, r, w, p, d);
        end

        for (int i = 0; i < 16; i++) begin
            applyStimulus(23'(i), 1'b1, 1'b0, 1'b0, 36'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
